// File: rtl/spi_fl_pkg.sv
// Shared constants for the SPI flash read path: opcodes, master config encodings
// and the burst sequencer state type.
package spi_fl_pkg;

    localparam logic [7:0] FL_OP_READ      = 8'h03;
    localparam logic [7:0] FL_OP_FAST_READ = 8'h0B;
    localparam logic [7:0] FL_OP_RDSR      = 8'h05;
    localparam logic [7:0] FL_OP_WREN      = 8'h06;

    localparam logic [2:0] CT_SINGLE = 3'b000;
    localparam logic [2:0] CT_DUAL   = 3'b001;
    localparam logic [2:0] CT_QUAD   = 3'b010;

    localparam logic [9:0] FRAME_DEFAULT = 10'h000;
    localparam logic [1:0] XIP_OFF       = 2'b00;

    localparam int               NDATA_W         = 7;
    localparam logic [NDATA_W-1:0] WORD_NDATA_BITS = 7'd32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_DATA,
        ST_WAIT_IDLE,
        ST_FIN
    } rd_state_e;

    // Word-to-word byte address step; wraps naturally at 24 bits.
    function automatic logic [23:0] next_word_addr(input logic [23:0] a);
        return a + 24'd4;
    endfunction

endpackage

// File: rtl/spi_fl_rdfifo.sv
// Synchronous read-data FIFO; simultaneous push/pop allowed when full or empty,
// flush clears all entries in one cycle.
module spi_fl_rdfifo #(
    parameter int DEPTH = 4,
    parameter int W     = 32,
    localparam int AW    = $clog2(DEPTH),
    localparam int CNT_W = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [W-1:0]     wdata,
    input  logic             pop,
    input  logic             flush,
    output logic [W-1:0]     rdata,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; pointers and count define validity,
    // and leaving the array reset-free lets it map to plain RAM/flops without reset.
    always_ff @(posedge clk) begin
        if (do_push && !flush && !rst) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/spi_fl_rd_seq.sv
// Burst-read sequencer for spi_master_fl: splits a burst into single-word fast reads,
// one in flight at a time, and buffers returned words in a small stream FIFO.
module spi_fl_rd_seq #(
    parameter int          FIFO_DEPTH  = 4,
    parameter logic [7:0]  RD_CMD      = spi_fl_pkg::FL_OP_FAST_READ,
    parameter logic [2:0]  RD_COMMTYPE = spi_fl_pkg::CT_SINGLE,
    parameter logic [9:0]  RD_FRAME    = spi_fl_pkg::FRAME_DEFAULT,
    parameter logic [1:0]  RD_XIP      = spi_fl_pkg::XIP_OFF,
    parameter logic [3:0]  RD_DUMMY    = 4'd8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [23:0] req_addr,
    input  logic [7:0]  req_nwords,
    input  logic        abort,
    output logic        busy,
    output logic        done,
    output logic [31:0] rd_data,
    output logic        rd_valid,
    input  logic        rd_ready,
    output logic [7:0]  m_command,
    output logic [23:0] m_address,
    output logic [31:0] m_data_in,
    output logic [2:0]  m_commtype,
    output logic [6:0]  m_ndata_bits,
    output logic [9:0]  m_frame_struct,
    output logic [1:0]  m_xipbit_en,
    output logic [3:0]  m_dummy_cycles,
    output logic        m_validflag,
    input  logic [31:0] m_data_out,
    input  logic        m_validflag_out,
    input  logic        m_tready
);

    import spi_fl_pkg::*;

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    rd_state_e        state;
    logic [23:0]      addr_q;
    logic [7:0]       cnt_q;
    logic             abort_q;
    logic             abort_any;
    logic             fifo_push;
    logic             fifo_flush;
    logic             fifo_empty;
    logic             fifo_full;
    logic [CNT_W-1:0] fifo_count;

    assign abort_any  = abort_q || abort;
    // A word returning after abort is dropped; the flush in FIN covers earlier ones.
    assign fifo_push  = (state == ST_WAIT_DATA) && m_validflag_out && !abort_any && !fifo_full;
    assign fifo_flush = (state == ST_FIN) && abort_any;

    assign req_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_FIN);
    assign rd_valid  = !fifo_empty;

    assign m_data_in      = 32'd0;
    assign m_commtype     = RD_COMMTYPE;
    assign m_ndata_bits   = WORD_NDATA_BITS;
    assign m_frame_struct = RD_FRAME;
    assign m_xipbit_en    = RD_XIP;
    assign m_dummy_cycles = RD_DUMMY;

    spi_fl_rdfifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (32)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .wdata (m_data_out),
        .pop   (rd_ready),
        .flush (fifo_flush),
        .rdata (rd_data),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            addr_q      <= '0;
            cnt_q       <= '0;
            abort_q     <= 1'b0;
            m_validflag <= 1'b0;
            m_address   <= '0;
            m_command   <= '0;
        end else begin
            m_validflag <= 1'b0;
            if (state != ST_IDLE) abort_q <= abort_any;

            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        addr_q <= req_addr & ~24'h3;
                        cnt_q  <= req_nwords;
                        state  <= (req_nwords == 8'd0) ? ST_FIN : ST_ISSUE;
                    end
                end
                // Only one command is ever in flight, so a free slot now is a
                // guaranteed home for the word this command returns.
                ST_ISSUE: begin
                    if (abort_any) begin
                        state <= ST_FIN;
                    end else if (m_tready && (fifo_count < CNT_W'(FIFO_DEPTH))) begin
                        m_validflag <= 1'b1;
                        m_address   <= addr_q;
                        m_command   <= RD_CMD;
                        state       <= ST_WAIT_DATA;
                    end
                end
                ST_WAIT_DATA: begin
                    if (m_validflag_out) state <= ST_WAIT_IDLE;
                end
                ST_WAIT_IDLE: begin
                    if (m_tready) begin
                        addr_q <= next_word_addr(addr_q);
                        cnt_q  <= cnt_q - 8'd1;
                        state  <= ((cnt_q == 8'd1) || abort_any) ? ST_FIN : ST_ISSUE;
                    end
                end
                ST_FIN: begin
                    abort_q <= 1'b0;
                    state   <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_fl_rd_seq.sv
// Directed bench for spi_fl_rd_seq with a behavioural master model and a
// queue-based scoreboard checked by an independent monitor.
module tb_spi_fl_rd_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [23:0] req_addr;
    logic [7:0]  req_nwords;
    logic        abort;
    logic        busy;
    logic        done;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        rd_ready;
    logic [7:0]  m_command;
    logic [23:0] m_address;
    logic [31:0] m_data_in;
    logic [2:0]  m_commtype;
    logic [6:0]  m_ndata_bits;
    logic [9:0]  m_frame_struct;
    logic [1:0]  m_xipbit_en;
    logic [3:0]  m_dummy_cycles;
    logic        m_validflag;
    logic [31:0] m_data_out;
    logic        m_validflag_out;
    logic        m_tready;

    always #5 clk = ~clk;

    spi_fl_rd_seq dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_addr        (req_addr),
        .req_nwords      (req_nwords),
        .abort           (abort),
        .busy            (busy),
        .done            (done),
        .rd_data         (rd_data),
        .rd_valid        (rd_valid),
        .rd_ready        (rd_ready),
        .m_command       (m_command),
        .m_address       (m_address),
        .m_data_in       (m_data_in),
        .m_commtype      (m_commtype),
        .m_ndata_bits    (m_ndata_bits),
        .m_frame_struct  (m_frame_struct),
        .m_xipbit_en     (m_xipbit_en),
        .m_dummy_cycles  (m_dummy_cycles),
        .m_validflag     (m_validflag),
        .m_data_out      (m_data_out),
        .m_validflag_out (m_validflag_out),
        .m_tready        (m_tready)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cmd_seen  = 0;
    int done_seen = 0;
    int word_seen = 0;
    int lat = 3;

    logic [23:0] exp_cmd_q  [$];
    logic [31:0] exp_data_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Behavioural master: returns {8'hD0, address} 'lat' cycles after a start pulse.
    int          m_state = 0;
    int          m_cnt   = 0;
    logic [23:0] m_cap   = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_tready        <= 1'b1;
            m_validflag_out <= 1'b0;
            m_data_out      <= '0;
            m_state         <= 0;
            m_cnt           <= 0;
        end else begin
            m_validflag_out <= 1'b0;
            case (m_state)
                0: if (m_validflag) begin
                    m_tready <= 1'b0;
                    m_cap    <= m_address;
                    m_cnt    <= lat;
                    m_state  <= 1;
                end
                1: if (m_cnt <= 1) begin
                    m_validflag_out <= 1'b1;
                    m_data_out      <= {8'hD0, m_cap};
                    m_state         <= 2;
                end else begin
                    m_cnt <= m_cnt - 1;
                end
                default: begin
                    m_tready <= 1'b1;
                    m_state  <= 0;
                end
            endcase
        end
    end

    // Monitor: compares DUT activity against the scoreboard queues.
    always @(negedge clk) begin
        if (!rst) begin
            if (m_validflag) begin
                cmd_seen++;
                if (exp_cmd_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_cmd: got addr 0x%0h, none expected", m_address);
                end else begin
                    check("cmd_addr", 32'(m_address), 32'(exp_cmd_q.pop_front()));
                    check("cmd_opcode", 32'(m_command), 32'h0B);
                end
            end
            if (m_validflag_out)
                check("addr_stable", 32'(m_address), 32'(m_cap));
            if (rd_valid && rd_ready) begin
                word_seen++;
                if (exp_data_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_word: got 0x%0h, none expected", rd_data);
                end else begin
                    check("rd_data", rd_data, exp_data_q.pop_front());
                end
            end
            if (done) done_seen++;
        end
    end

    task automatic step(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic send_req(input logic [23:0] a, input logic [7:0] n);
        @(posedge clk);
        #1;
        req_addr   = a;
        req_nwords = n;
        req_valid  = 1'b1;
        check("req_ready_before", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        bit got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            if (done) got = 1'b1;
        end
        check({name, "_done_seen"}, 32'(got), 32'd1);
    endtask

    task automatic wait_cmds(input string name, input int target, input int budget);
        bit got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            if (cmd_seen >= target) got = 1'b1;
        end
        check({name, "_cmd_reached"}, 32'(got), 32'd1);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_req_ready"},   32'(req_ready),   32'd1);
        check({name, "_busy"},        32'(busy),        32'd0);
        check({name, "_done"},        32'(done),        32'd0);
        check({name, "_rd_valid"},    32'(rd_valid),    32'd0);
        check({name, "_m_validflag"}, 32'(m_validflag), 32'd0);
        check({name, "_m_address"},   32'(m_address),   32'd0);
    endtask

    task automatic check_drained(input string name);
        check({name, "_cmd_q_left"},  32'(exp_cmd_q.size()),  32'd0);
        check({name, "_data_q_left"}, 32'(exp_data_q.size()), 32'd0);
        check({name, "_rd_valid"},    32'(rd_valid),          32'd0);
        check({name, "_req_ready"},   32'(req_ready),         32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int d0;
        int w0;

        rst        = 1'b1;
        req_valid  = 1'b0;
        req_addr   = '0;
        req_nwords = '0;
        abort      = 1'b0;
        rd_ready   = 1'b1;
        step(3);
        rst = 1'b0;
        #1;
        check_reset_outputs("reset");
        check("cfg_data_in",   m_data_in,              32'd0);
        check("cfg_ndata",     32'(m_ndata_bits),      32'd32);
        check("cfg_commtype",  32'(m_commtype),        32'd0);
        check("cfg_frame",     32'(m_frame_struct),    32'd0);
        check("cfg_xip",       32'(m_xipbit_en),       32'd0);
        check("cfg_dummy",     32'(m_dummy_cycles),    32'd8);

        // 1: three-word burst in order
        lat = 3;
        exp_cmd_q  = '{24'h000100, 24'h000104, 24'h000108};
        exp_data_q = '{32'hD0000100, 32'hD0000104, 32'hD0000108};
        c0 = cmd_seen; d0 = done_seen;
        send_req(24'h000100, 8'd3);
        check("t1_busy", 32'(busy), 32'd1);
        wait_done("t1", 200);
        step(6);
        check("t1_cmds",  32'(cmd_seen - c0),  32'd3);
        check("t1_dones", 32'(done_seen - d0), 32'd1);
        check_drained("t1");

        // 2: zero-length request
        c0 = cmd_seen; d0 = done_seen;
        send_req(24'h000040, 8'd0);
        check("t2_done_hi", 32'(done), 32'd1);
        check("t2_busy_hi", 32'(busy), 32'd1);
        step(1);
        check("t2_done_lo",  32'(done),          32'd0);
        check("t2_busy_lo",  32'(busy),          32'd0);
        check("t2_cmds",     32'(cmd_seen - c0), 32'd0);
        check("t2_dones",    32'(done_seen - d0), 32'd1);

        // unaligned start address is forced to a word boundary
        exp_cmd_q  = '{24'h000010};
        exp_data_q = '{32'hD0000010};
        send_req(24'h000013, 8'd1);
        wait_done("ta", 200);
        step(6);
        check_drained("ta");

        // 3: 24-bit address wrap
        lat = 5;
        exp_cmd_q  = '{24'hFFFFF8, 24'hFFFFFC, 24'h000000};
        exp_data_q = '{32'hD0FFFFF8, 32'hD0FFFFFC, 32'hD0000000};
        c0 = cmd_seen;
        send_req(24'hFFFFF8, 8'd3);
        wait_done("t3", 300);
        step(6);
        check("t3_cmds", 32'(cmd_seen - c0), 32'd3);
        check_drained("t3");

        // 4: FIFO back-pressure stalls issue after four words
        lat = 2;
        rd_ready   = 1'b0;
        exp_cmd_q  = '{24'h000200, 24'h000204, 24'h000208, 24'h00020C, 24'h000210, 24'h000214};
        exp_data_q = '{32'hD0000200, 32'hD0000204, 32'hD0000208,
                       32'hD000020C, 32'hD0000210, 32'hD0000214};
        c0 = cmd_seen; d0 = done_seen; w0 = word_seen;
        send_req(24'h000200, 8'd6);
        wait_cmds("t4", c0 + 4, 300);
        step(40);
        check("t4_stall_cmds", 32'(cmd_seen - c0), 32'd4);
        check("t4_stall_busy", 32'(busy),          32'd1);
        check("t4_stall_rdv",  32'(rd_valid),      32'd1);
        rd_ready = 1'b1;
        wait_done("t4", 300);
        step(6);
        check("t4_cmds",  32'(cmd_seen - c0),  32'd6);
        check("t4_words", 32'(word_seen - w0), 32'd6);
        check("t4_dones", 32'(done_seen - d0), 32'd1);
        check_drained("t4");

        // 5: abort during the second frame
        lat = 4;
        exp_cmd_q  = '{24'h000300, 24'h000304};
        exp_data_q = '{32'hD0000300};
        c0 = cmd_seen; d0 = done_seen;
        send_req(24'h000300, 8'd5);
        wait_cmds("t5", c0 + 2, 300);
        step(1);
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        wait_done("t5", 300);
        step(1);
        check("t5_rd_valid",  32'(rd_valid),  32'd0);
        check("t5_req_ready", 32'(req_ready), 32'd1);
        step(20);
        check("t5_cmds",  32'(cmd_seen - c0),  32'd2);
        check("t5_dones", 32'(done_seen - d0), 32'd1);
        check_drained("t5");

        // 6: reset mid-burst, then a fresh request
        lat = 6;
        exp_cmd_q = '{24'h000400};
        c0 = cmd_seen;
        send_req(24'h000400, 8'd3);
        wait_cmds("t6", c0 + 1, 300);
        step(1);
        rst = 1'b1;
        step(1);
        check_reset_outputs("t6_rst");
        rst = 1'b0;
        exp_cmd_q  = '{24'h000500};
        exp_data_q = '{32'hD0000500};
        d0 = done_seen;
        send_req(24'h000500, 8'd1);
        wait_done("t6", 200);
        step(6);
        check("t6_dones", 32'(done_seen - d0), 32'd1);
        check_drained("t6");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
